// File: rtl/fir_cntrl.sv
// fir_cntrl: top-level controller of the programmable FIR engine.
// Walks an internal coefficient ROM row by row. For each row it loads the taps,
// clears the sample delay line, streams every sample from the sample ROM through
// ORDER+1 multiply units plus an adder, and emits one y per sample.
// Build option: define CNTRL_DIAG_EN to expose internal state on *_test ports.
module fir_cntrl #(
  parameter int BITS  = 16,
  parameter int ORDER = 4,
  parameter int ROWS  = 16
) (
  input  logic                       dpu_clk,
  input  logic                       rst_n,
  output logic signed [2*BITS-1:0]   y,
  output logic                       y_valid
`ifdef CNTRL_DIAG_EN
  ,
  output logic [2:0]                 state_test,
  output logic [$clog2(ROWS)-1:0]    row_test,
  output logic [$clog2(ROWS)-1:0]    idx_test,
  output logic [BITS*(ORDER+1)-1:0]  h_regs_test,
  output logic [BITS*(ORDER+1)-1:0]  x_regs_test,
  output logic [2*BITS*(ORDER+1)-1:0] dpu_y_test,
  output logic [ORDER:0]             dpu_enables_test
`endif
);

  localparam int AW = $clog2(ROWS);

  // Encodings are visible on state_test, so keep them fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_H = 3'd1,
    CLEAR  = 3'd2,
    FETCH  = 3'd3,
    MAC    = 3'd4,
    SUM    = 3'd5,
    NEXT   = 3'd6
  } state_t;

  state_t                    state;
  logic [AW-1:0]             row;
  logic [AW-1:0]             idx;
  logic signed [BITS-1:0]    h [0:ORDER];
  logic signed [BITS-1:0]    x [0:ORDER];
  logic signed [2*BITS-1:0]  p [0:ORDER];
  logic signed [2*BITS-1:0]  sum_p;
  logic [ORDER:0]            dpu_en;

  // Coefficient ROM: h_rom[r][k] = r+k+1, truncated to BITS.
  function automatic logic signed [BITS-1:0] h_rom(input logic [AW-1:0] r, input int k);
    int v;
    v = int'(r) + k + 1;
    return BITS'(v);
  endfunction

  // Sample ROM: x_rom[n] = n+1, truncated to BITS.
  function automatic logic signed [BITS-1:0] x_rom(input logic [AW-1:0] n);
    int v;
    v = int'(n) + 1;
    return BITS'(v);
  endfunction

  // Adder tree over all products; wraps modulo 2^(2*BITS).
  always_comb begin
    sum_p = '0;
    for (int k = 0; k <= ORDER; k++) begin
      sum_p = sum_p + p[k];
    end
  end

  // Multiply units are only enabled while the FSM is in MAC.
  always_comb begin
    dpu_en = (state == MAC) ? '1 : '0;
  end

  // Main controller FSM with datapath registers and registered outputs.
  always_ff @(posedge dpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row     <= '0;
      idx     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      for (int k = 0; k <= ORDER; k++) begin
        h[k] <= '0;
        x[k] <= '0;
        p[k] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= LOAD_H;
        end
        LOAD_H: begin
          for (int k = 0; k <= ORDER; k++) begin
            h[k] <= h_rom(row, k);
          end
          state <= CLEAR;
        end
        CLEAR: begin
          // Each row starts with an empty delay line.
          for (int k = 0; k <= ORDER; k++) begin
            x[k] <= '0;
          end
          idx   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          x[0] <= x_rom(idx);
          for (int k = 1; k <= ORDER; k++) begin
            x[k] <= x[k-1];
          end
          state <= MAC;
        end
        MAC: begin
          // Operands sign-extended to full width; the exact product fits.
          for (int k = 0; k <= ORDER; k++) begin
            if (dpu_en[k]) begin
              p[k] <= (2*BITS)'(h[k]) * (2*BITS)'(x[k]);
            end
          end
          state <= SUM;
        end
        SUM: begin
          y       <= sum_p;
          y_valid <= 1'b1;
          if (idx == AW'(ROWS - 1)) begin
            state <= NEXT;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        NEXT: begin
          row   <= (row == AW'(ROWS - 1)) ? '0 : row + 1'b1;
          state <= LOAD_H;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CNTRL_DIAG_EN
  // Flatten internal registers onto the diagnostic ports.
  always_comb begin
    state_test       = state;
    row_test         = row;
    idx_test         = idx;
    dpu_enables_test = dpu_en;
    h_regs_test      = '0;
    x_regs_test      = '0;
    dpu_y_test       = '0;
    for (int k = 0; k <= ORDER; k++) begin
      h_regs_test[k*BITS +: BITS]     = h[k];
      x_regs_test[k*BITS +: BITS]     = x[k];
      dpu_y_test[k*2*BITS +: 2*BITS]  = p[k];
    end
  end
`endif

endmodule

// File: tb/tb_fir_cntrl.sv
// tb_fir_cntrl: directed bench for fir_cntrl (BITS=16, ORDER=4, ROWS=16).
// Expected y values come from hand-computed tables and the closed form
// y[r][n] = sum_k (r+k+1)*(n-k+1) over n-k >= 0.
module tb_fir_cntrl;

  logic               dpu_clk = 1'b0;
  logic               rst_n   = 1'b0;
  logic signed [31:0] y;
  logic               y_valid;

`ifdef CNTRL_DIAG_EN
  logic [2:0]   state_test;
  logic [3:0]   row_test;
  logic [3:0]   idx_test;
  logic [79:0]  h_regs_test;
  logic [79:0]  x_regs_test;
  logic [159:0] dpu_y_test;
  logic [4:0]   dpu_enables_test;
`endif

  int errors = 0;
  int checks = 0;

  fir_cntrl #(.BITS(16), .ORDER(4), .ROWS(16)) dut (
    .dpu_clk (dpu_clk),
    .rst_n   (rst_n),
    .y       (y),
    .y_valid (y_valid)
`ifdef CNTRL_DIAG_EN
    ,
    .state_test       (state_test),
    .row_test         (row_test),
    .idx_test         (idx_test),
    .h_regs_test      (h_regs_test),
    .x_regs_test      (x_regs_test),
    .dpu_y_test       (dpu_y_test),
    .dpu_enables_test (dpu_enables_test)
`endif
  );

  // Clock
  always #5 dpu_clk = ~dpu_clk;

  // Closed-form reference: row r taps are r+1..r+5, samples are n+1.
  function automatic int exp_y(input int r, input int n);
    int s;
    s = 0;
    for (int k = 0; k <= 4; k++) begin
      if (n - k >= 0) s = s + (r + k + 1) * (n - k + 1);
    end
    return s;
  endfunction

  // Waits for the next y_valid pulse, sampled 1 time unit after each rising edge.
  // Returns the number of edges waited and whether a pulse was seen in budget.
  task automatic wait_pulse(input int budget, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (cyc < budget && !got) begin
      @(posedge dpu_clk);
      #1;
      cyc++;
      if (y_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge dpu_clk);
      #1;
      checks++;
      if (y !== 32'sd0 || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: y=%0d y_valid=%b, required y=0 y_valid=0", i, y, y_valid);
      end
    end
    @(negedge dpu_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_row();
    int cyc;
    bit got;
    int head [6] = '{1, 4, 10, 20, 35, 50};
    int req;
    for (int n = 0; n < 16; n++) begin
      wait_pulse(12, cyc, got);
      checks++;
      if (!got || cyc !== ((n == 0) ? 6 : 3)) begin
        errors++;
        $display("FAIL row0_gap n=%0d: waited %0d (pulse=%0b), required %0d", n, cyc, got, (n == 0) ? 6 : 3);
      end
      req = (n < 6) ? head[n] : (15 * n - 25);
      checks++;
      if (y !== req) begin
        errors++;
        $display("FAIL row0_y n=%0d: y=%0d, required %0d", n, y, req);
      end
    end
    checks++;
    if (y !== 32'sd200) begin
      errors++;
      $display("FAIL row0_last: y=%0d, required 200", y);
    end
  endtask

  task automatic test_row_wrap();
    int cyc;
    bit got;
    int row1_head [3] = '{2, 7, 16};
    int req;
    for (int r = 1; r < 16; r++) begin
      for (int n = 0; n < 16; n++) begin
        wait_pulse(12, cyc, got);
        checks++;
        if (!got || cyc !== ((n == 0) ? 6 : 3)) begin
          errors++;
          $display("FAIL row%0d_gap n=%0d: waited %0d (pulse=%0b), required %0d", r, n, cyc, got, (n == 0) ? 6 : 3);
        end
        req = (r == 1 && n < 3) ? row1_head[n] : exp_y(r, n);
        checks++;
        if (y !== req) begin
          errors++;
          $display("FAIL row%0d_y n=%0d: y=%0d, required %0d", r, n, y, req);
        end
        if (r == 15 && n == 0) begin
          checks++;
          if (y !== 32'sd16) begin
            errors++;
            $display("FAIL row15_first: y=%0d, required 16", y);
          end
        end
      end
    end
    // Back to row 0 after the last row.
    wait_pulse(12, cyc, got);
    checks++;
    if (!got || cyc !== 6 || y !== 32'sd1) begin
      errors++;
      $display("FAIL wrap_row0: waited %0d y=%0d, required 6 cycles and y=1", cyc, y);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit got;
    int restart [3] = '{1, 4, 10};
    int req;
    // Finish row 0 (sample 0 already consumed), all of row 1, and three samples of row 2.
    for (int step = 1; step < 35; step++) begin
      int r;
      int n;
      r = step / 16;
      n = step % 16;
      wait_pulse(12, cyc, got);
      req = exp_y(r, n);
      checks++;
      if (!got || y !== req) begin
        errors++;
        $display("FAIL pre_abort r=%0d n=%0d: y=%0d (pulse=%0b), required %0d", r, n, y, got, req);
      end
    end
    // Drop reset between edges while y_valid is high and y is nonzero.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 32'sd0 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_now: y=%0d y_valid=%b, required y=0 y_valid=0", y, y_valid);
    end
    repeat (3) @(posedge dpu_clk);
    @(negedge dpu_clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_pulse(12, cyc, got);
      req = restart[n];
      checks++;
      if (!got || cyc !== ((n == 0) ? 6 : 3) || y !== req) begin
        errors++;
        $display("FAIL restart n=%0d: waited %0d y=%0d, required %0d cycles y=%0d", n, cyc, y, (n == 0) ? 6 : 3, req);
      end
    end
  endtask

`ifdef CNTRL_DIAG_EN
  task automatic test_diag();
    int cyc;
    bit got;
    logic [2:0] walk [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [4:0] en_req;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_test !== 3'd0 || dpu_enables_test !== 5'd0 || h_regs_test !== 80'd0 || dpu_y_test !== 160'd0) begin
      errors++;
      $display("FAIL diag_reset: state=%0d en=%b, required 0 and 0", state_test, dpu_enables_test);
    end
    @(negedge dpu_clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge dpu_clk);
        #1;
      end
      en_req = (walk[i] == 3'd4) ? 5'b11111 : 5'b00000;
      checks++;
      if (state_test !== walk[i] || dpu_enables_test !== en_req) begin
        errors++;
        $display("FAIL diag_walk step %0d: state=%0d en=%b, required %0d %b", i, state_test, dpu_enables_test, walk[i], en_req);
      end
    end
    // Run to the end of row 0; the last pulse leaves the FSM in NEXT.
    for (int n = 0; n < 16; n++) wait_pulse(12, cyc, got);
    checks++;
    if (!got || y !== 32'sd200 || state_test !== 3'd6 || dpu_enables_test !== 5'd0) begin
      errors++;
      $display("FAIL diag_next: y=%0d state=%0d en=%b, required 200 6 00000", y, state_test, dpu_enables_test);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_row();
    test_row_wrap();
    test_mid_reset();
`ifdef CNTRL_DIAG_EN
    test_diag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
